max_sort_engine: RTL and testbench
==================================

MAX_SORT_ENGINE -- requirements
Module: max_sort_engine

Interface
REQ-001 Parameter M, default 8, number of words per sort set; legal range is M >= 1.
REQ-002 Parameter N, default 16, word width in bits; legal range is N >= 1.
REQ-003 Parameter DESCENDING, default 1; 1 emits the largest word first, 0 emits the smallest word first.
REQ-004 Localparam IW = max(1, clog2(M)) SHALL size the index port.
REQ-005 i_clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-high.
REQ-007 i_valid  input  1  input set valid.
REQ-008 o_ready  output  1  engine accepts a new set.
REQ-009 i_data  input  [M-1:0][N-1:0]  word k is i_data[k].
REQ-010 o_valid  output  1  output element valid.
REQ-011 i_ready  input  1  downstream accepts the output element.
REQ-012 o_data  output  N  emitted word.
REQ-013 o_index  output  IW  original position k of the emitted word.
REQ-014 o_last  output  1  marks the M-th element of a set.
REQ-015 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SORT and DRAIN; o_ready SHALL be 1 only in IDLE.
REQ-017 IDLE->SORT on i_valid&o_ready: register all M words, set active mask to all ones, clear the emit counter.
REQ-018 While not in IDLE, i_valid SHALL be ignored and i_data SHALL NOT be sampled.
REQ-019 Selection SHALL be combinational over registered words using MSB-first bit-slice elimination with no magnitude comparators: cand = active; for j = N-1 downto 0: s = cand & slice_j (DESCENDING=1) or cand & ~slice_j (DESCENDING=0); cand = s if s != 0, else cand unchanged.
REQ-020 Winner SHALL be the lowest index set in the final cand, which gives stable order on ties.
REQ-021 An advance SHALL occur in SORT when (!o_valid | i_ready).
REQ-022 On an advance, the winner's word and index SHALL be loaded into o_data/o_index, o_valid set to 1, the winner's active bit cleared, and the counter incremented.
REQ-023 o_last SHALL be 1 on the advance whose counter value before increment equals M-1; that advance SHALL transition SORT->DRAIN.
REQ-024 DRAIN->IDLE when o_valid&i_ready; o_valid, o_last SHALL clear on that edge; o_ready SHALL be 1 the following cycle.
REQ-025 In SORT, an o_valid&i_ready handshake with no pending element SHALL NOT occur, because each handshake coincides with an advance.
REQ-026 While o_valid=1 and i_ready=0, o_data, o_index, o_last, the active mask and the counter SHALL hold stable.
REQ-027 Latency: first o_valid SHALL be 1 on the cycle after the input handshake.
REQ-028 Throughput: with i_ready held at 1, one element per cycle; a set occupies M+1 cycles from accept to IDLE.
REQ-029 M=1: the single word SHALL be emitted with o_index=0 and o_last=1 on the first advance.
REQ-030 The all-zero set and the all-equal set SHALL emit indices 0..M-1 in ascending order.
REQ-031 Each index SHALL be emitted exactly once per set; the active mask SHALL be all zeros on entering DRAIN.

Reset
REQ-032 While i_rst=1: state=IDLE, o_valid=0, o_last=0, o_data=0, o_index=0, o_busy=0, o_ready=0, active mask=0, counter=0.
REQ-033 o_ready SHALL rise on the first cycle after i_rst deasserts.
REQ-034 Reset asserted mid-sort or mid-stall SHALL abandon the set: no further o_valid until a new input handshake.

Verification
REQ-035 M=4, N=8, DESCENDING=1, i_data={k0:0x12, k1:0xF0, k2:0x12, k3:0x07}, i_ready=1 -> (0xF0,1), (0x12,0), (0x12,2), (0x07,3, o_last) on 4 consecutive cycles starting 1 cycle after accept.
REQ-036 Same set with DESCENDING=0 -> (0x07,3), (0x12,0), (0x12,2), (0xF0,1, o_last).
REQ-037 Same set, i_ready=0 for 3 cycles after the first o_valid -> (0xF0,1) held stable for 3 cycles; the remaining order is unchanged.
REQ-038 All words 0x00 -> indices 0,1,2,3 emitted; o_last on index 3.
REQ-039 i_rst pulsed for 1 cycle after the second element -> o_valid=0 next cycle and o_ready=1 the cycle after; a new set sorts correctly.
REQ-040 M=1, i_data=0x5A -> single element (0x5A, 0, o_last) one cycle after accept; i_valid held high during busy is not accepted until IDLE.

Source files
------------

// File: rtl/max_sort_engine.sv
// Streaming max/min sort engine: captures M words, then emits them one per
// advance in sorted order using MSB-first bit-slice elimination.
module max_sort_engine #(
  parameter int unsigned M          = 8,
  parameter int unsigned N          = 16,
  parameter bit          DESCENDING = 1'b1,
  localparam int unsigned IW        = (M > 1) ? $clog2(M) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [M-1:0][N-1:0]   i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [N-1:0]          o_data,
  output logic [IW-1:0]         o_index,
  output logic                  o_last,
  output logic                  o_busy
);

  localparam int unsigned CW = $clog2(M + 1);

  typedef enum logic [1:0] {IDLE, SORT, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [M-1:0][N-1:0]  words_q;
  logic [M-1:0]         active_q;
  logic [CW-1:0]        cnt_q;

  logic                 accept;
  logic                 advance;
  logic                 drain_done;

  logic [M-1:0]         cand;
  logic [M-1:0]         slice;
  logic [M-1:0]         sel;
  logic [IW-1:0]        win_idx;

  // Winner selection: narrow the candidate set one bit slice at a time, keeping
  // the survivors only when at least one candidate carries the preferred bit.
  always_comb begin
    cand    = active_q;
    slice   = '0;
    sel     = '0;
    win_idx = '0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      for (int k = 0; k < int'(M); k++) begin
        slice[k] = words_q[k][j];
      end
      sel = DESCENDING ? (cand & slice) : (cand & ~slice);
      if (sel != '0) begin
        cand = sel;
      end
    end
    // Lowest surviving index wins so equal words keep their input order.
    for (int k = int'(M) - 1; k >= 0; k--) begin
      if (cand[k]) begin
        win_idx = IW'(k);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    advance    = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && o_ready) begin
          accept  = 1'b1;
          state_d = SORT;
        end
      end
      SORT: begin
        if (!o_valid || i_ready) begin
          advance = 1'b1;
          if (cnt_q == CW'(M - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (o_valid && i_ready) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      words_q  <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_data   <= '0;
      o_index  <= '0;
      o_ready  <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_ready <= (state_d == IDLE);
      o_busy  <= (state_d != IDLE);
      if (accept) begin
        words_q  <= i_data;
        active_q <= '1;
        cnt_q    <= '0;
      end
      if (advance) begin
        o_data            <= words_q[win_idx];
        o_index           <= win_idx;
        o_valid           <= 1'b1;
        o_last            <= (cnt_q == CW'(M - 1));
        active_q[win_idx] <= 1'b0;
        cnt_q             <= cnt_q + CW'(1);
      end
      if (drain_done) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_max_sort_engine.sv
// Directed bench for max_sort_engine: descending and ascending M=4 instances
// share stimulus; a separate M=1 instance covers the single-word case.
module tb_max_sort_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             v4, rdy4;
  logic [3:0][7:0]  d4;
  logic             dn_ready, dn_valid, dn_last, dn_busy;
  logic [7:0]       dn_data;
  logic [1:0]       dn_index;
  logic             up_ready, up_valid, up_last, up_busy;
  logic [7:0]       up_data;
  logic [1:0]       up_index;
  logic             v1, rdy1;
  logic [0:0][7:0]  d1;
  logic             m1_ready, m1_valid, m1_last, m1_busy;
  logic [7:0]       m1_data;
  logic [0:0]       m1_index;

  max_sort_engine #(.M(4), .N(8), .DESCENDING(1'b1)) u_dn (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(dn_ready), .i_data(d4),
    .o_valid(dn_valid), .i_ready(rdy4), .o_data(dn_data), .o_index(dn_index),
    .o_last(dn_last), .o_busy(dn_busy));

  max_sort_engine #(.M(4), .N(8), .DESCENDING(1'b0)) u_up (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(up_ready), .i_data(d4),
    .o_valid(up_valid), .i_ready(rdy4), .o_data(up_data), .o_index(up_index),
    .o_last(up_last), .o_busy(up_busy));

  max_sort_engine #(.M(1), .N(8), .DESCENDING(1'b1)) u_m1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(m1_ready), .i_data(d1),
    .o_valid(m1_valid), .i_ready(rdy1), .o_data(m1_data), .o_index(m1_index),
    .o_last(m1_last), .o_busy(m1_busy));

  typedef struct {
    logic [3:0][7:0] din;
    logic [3:0][7:0] dn_d;
    logic [3:0][1:0] dn_i;
    logic [3:0][7:0] up_d;
    logic [3:0][1:0] up_i;
  } vec_t;

  vec_t vt[5];

  int cmp_n = 0;
  int err_n = 0;
  int cyc_cnt = 0;

  logic [7:0] dn_d[4], up_d[4];
  logic [1:0] dn_i[4], up_i[4];
  logic       dn_l[4], up_l[4];
  int         dn_n, up_n, dn_first, dn_last_cyc;

  function automatic logic [3:0][7:0] w4(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [3:0][1:0] i4(input logic [1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic wait_ready4();
    int n = 0;
    while (!(dn_ready && up_ready) && n < 50) begin
      step();
      n++;
    end
    chk("wait_ready4", 32'(dn_ready && up_ready), 32'd1);
  endtask

  // Samples both M=4 outputs from the current cycle onward until 4 elements each.
  task automatic collect();
    dn_n = 0;
    up_n = 0;
    dn_first = 0;
    dn_last_cyc = 0;
    for (int c = 0; c < 30; c++) begin
      if (dn_valid && rdy4 && dn_n < 4) begin
        dn_d[dn_n] = dn_data; dn_i[dn_n] = dn_index; dn_l[dn_n] = dn_last;
        if (dn_n == 0) dn_first = c;
        dn_last_cyc = c;
        dn_n++;
      end
      if (up_valid && rdy4 && up_n < 4) begin
        up_d[up_n] = up_data; up_i[up_n] = up_index; up_l[up_n] = up_last;
        up_n++;
      end
      if (dn_n == 4 && up_n == 4) break;
      step();
    end
    chk("dn_count", 32'(dn_n), 32'd4);
    chk("up_count", 32'(up_n), 32'd4);
  endtask

  task automatic compare_set(input int v);
    for (int e = 0; e < dn_n; e++) begin
      chk($sformatf("v%0d_dn_data%0d", v, e), 32'(dn_d[e]), 32'(vt[v].dn_d[e]));
      chk($sformatf("v%0d_dn_idx%0d", v, e), 32'(dn_i[e]), 32'(vt[v].dn_i[e]));
      chk($sformatf("v%0d_dn_last%0d", v, e), 32'(dn_l[e]), 32'(e == 3));
    end
    for (int e = 0; e < up_n; e++) begin
      chk($sformatf("v%0d_up_data%0d", v, e), 32'(up_d[e]), 32'(vt[v].up_d[e]));
      chk($sformatf("v%0d_up_idx%0d", v, e), 32'(up_i[e]), 32'(vt[v].up_i[e]));
      chk($sformatf("v%0d_up_last%0d", v, e), 32'(up_l[e]), 32'(e == 3));
    end
  endtask

  task automatic accept4(input logic [3:0][7:0] d);
    wait_ready4();
    d4 = d;
    v4 = 1'b1;
    step();
    v4 = 1'b0;
    d4 = '0;
  endtask

  initial begin
    int acc;
    int n;

    vt[0] = '{din: w4(8'h12, 8'hF0, 8'h12, 8'h07),
              dn_d: w4(8'hF0, 8'h12, 8'h12, 8'h07), dn_i: i4(2'd1, 2'd0, 2'd2, 2'd3),
              up_d: w4(8'h07, 8'h12, 8'h12, 8'hF0), up_i: i4(2'd3, 2'd0, 2'd2, 2'd1)};
    vt[1] = '{din: w4(8'h00, 8'h00, 8'h00, 8'h00),
              dn_d: w4(8'h00, 8'h00, 8'h00, 8'h00), dn_i: i4(2'd0, 2'd1, 2'd2, 2'd3),
              up_d: w4(8'h00, 8'h00, 8'h00, 8'h00), up_i: i4(2'd0, 2'd1, 2'd2, 2'd3)};
    vt[2] = '{din: w4(8'h55, 8'h55, 8'h55, 8'h55),
              dn_d: w4(8'h55, 8'h55, 8'h55, 8'h55), dn_i: i4(2'd0, 2'd1, 2'd2, 2'd3),
              up_d: w4(8'h55, 8'h55, 8'h55, 8'h55), up_i: i4(2'd0, 2'd1, 2'd2, 2'd3)};
    vt[3] = '{din: w4(8'h01, 8'h02, 8'h03, 8'h04),
              dn_d: w4(8'h04, 8'h03, 8'h02, 8'h01), dn_i: i4(2'd3, 2'd2, 2'd1, 2'd0),
              up_d: w4(8'h01, 8'h02, 8'h03, 8'h04), up_i: i4(2'd0, 2'd1, 2'd2, 2'd3)};
    vt[4] = '{din: w4(8'hFF, 8'h00, 8'h80, 8'h7F),
              dn_d: w4(8'hFF, 8'h80, 8'h7F, 8'h00), dn_i: i4(2'd0, 2'd2, 2'd3, 2'd1),
              up_d: w4(8'h00, 8'h7F, 8'h80, 8'hFF), up_i: i4(2'd1, 2'd3, 2'd2, 2'd0)};

    rst = 1'b1; v4 = 1'b0; rdy4 = 1'b1; d4 = '0;
    v1 = 1'b0; rdy1 = 1'b1; d1 = '0;
    step();
    step();
    chk("rst_valid", 32'(dn_valid), 32'd0);
    chk("rst_last", 32'(dn_last), 32'd0);
    chk("rst_data", 32'(dn_data), 32'd0);
    chk("rst_index", 32'(dn_index), 32'd0);
    chk("rst_busy", 32'(dn_busy), 32'd0);
    chk("rst_ready", 32'(dn_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(dn_ready), 32'd1);
    chk("ready_after_rst_up", 32'(up_ready), 32'd1);

    // Table: full-rate sets, order, o_last, throughput and return to idle.
    for (int v = 0; v < 5; v++) begin
      rdy4 = 1'b1;
      accept4(vt[v].din);
      acc = cyc_cnt;
      chk($sformatf("v%0d_busy", v), 32'(dn_busy), 32'd1);
      chk($sformatf("v%0d_not_ready", v), 32'(dn_ready), 32'd0);
      collect();
      compare_set(v);
      chk($sformatf("v%0d_back_to_back", v), 32'(dn_last_cyc - dn_first), 32'd3);
      step();
      chk($sformatf("v%0d_idle_ready", v), 32'(dn_ready), 32'd1);
      chk($sformatf("v%0d_idle_valid", v), 32'(dn_valid), 32'd0);
      chk($sformatf("v%0d_idle_busy", v), 32'(dn_busy), 32'd0);
      chk($sformatf("v%0d_occupancy", v), 32'(cyc_cnt - acc), 32'd5);
    end

    // Stall: first element must hold for 3 cycles of i_ready=0.
    rdy4 = 1'b0;
    accept4(vt[0].din);
    n = 0;
    while (!dn_valid && n < 20) begin
      step();
      n++;
    end
    chk("stall_first_valid", 32'(dn_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_valid%0d", c), 32'(dn_valid), 32'd1);
      chk($sformatf("stall_data%0d", c), 32'(dn_data), 32'hF0);
      chk($sformatf("stall_idx%0d", c), 32'(dn_index), 32'd1);
      chk($sformatf("stall_last%0d", c), 32'(dn_last), 32'd0);
      if (c < 2) step();
    end
    rdy4 = 1'b1;
    collect();
    compare_set(0);
    step();

    // Reset after the second element abandons the set.
    accept4(vt[3].din);
    n = 0;
    dn_n = 0;
    while (dn_n < 2 && n < 20) begin
      if (dn_valid) dn_n++;
      if (dn_n < 2) step();
      n++;
    end
    chk("pre_rst_elems", 32'(dn_n), 32'd2);
    chk("pre_rst_data1", 32'(dn_data), 32'h03);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(dn_valid), 32'd0);
    chk("midrst_ready", 32'(dn_ready), 32'd0);
    step();
    chk("postrst_ready", 32'(dn_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("postrst_quiet%0d", c), 32'(dn_valid | up_valid), 32'd0);
      step();
    end
    accept4(vt[4].din);
    collect();
    compare_set(4);
    step();

    // M=1: immediate o_last, and held i_valid not taken while busy.
    d1 = 8'h5A;
    v1 = 1'b1;
    step();
    chk("m1_busy", 32'(m1_busy), 32'd1);
    chk("m1_sort_ready", 32'(m1_ready), 32'd0);
    step();
    chk("m1_valid", 32'(m1_valid), 32'd1);
    chk("m1_data", 32'(m1_data), 32'h5A);
    chk("m1_index", 32'(m1_index), 32'd0);
    chk("m1_last", 32'(m1_last), 32'd1);
    chk("m1_drain_ready", 32'(m1_ready), 32'd0);
    d1 = 8'hC3;
    step();
    chk("m1_idle_valid", 32'(m1_valid), 32'd0);
    chk("m1_idle_ready", 32'(m1_ready), 32'd1);
    step();
    v1 = 1'b0;
    chk("m1_reaccept_busy", 32'(m1_busy), 32'd1);
    step();
    chk("m1_second_data", 32'(m1_data), 32'hC3);
    chk("m1_second_last", 32'(m1_last), 32'd1);
    step();
    chk("m1_end_valid", 32'(m1_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
